// File: rtl/sort_pkg.sv
// Shared definitions for the sort frame controller: FSM encoding and result-width extension.
package sort_pkg;

  localparam int SUM_EXTRA = 4;

  // IDLE wait | CLEAR engine clear | FEED accept samples | DRAIN engine settle | HOLD result
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } sort_state_e;

endpackage

// File: rtl/sort_frame_ctrl_if.sv
// Two-requester sample handshake between sample sources and the frame controller.
interface sort_frame_ctrl_if #(
  parameter int W = 12
);

  logic         ReqA;
  logic [W-1:0] DataA;
  logic         AckA;
  logic         ReqB;
  logic [W-1:0] DataB;
  logic         AckB;

  modport master (
    output ReqA, DataA, ReqB, DataB,
    input  AckA, AckB
  );

  modport slave (
    input  ReqA, DataA, ReqB, DataB,
    output AckA, AckB
  );

endinterface

// File: rtl/sort_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted most recently wins a tie.
module sort_rr_arb2 (
  input  logic       clk,
  input  logic       synrst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  // prio_b_q set means B was not granted most recently (A won last)
  logic prio_b_q, prio_b_d;

  always_comb begin
    grant_o  = 2'b00;
    prio_b_d = prio_b_q;
    if (en_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = prio_b_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
    if (grant_o[0]) begin
      prio_b_d = 1'b1;
    end else if (grant_o[1]) begin
      prio_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (synrst) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end

endmodule

// File: rtl/sort_frame_ctrl.sv
// Frame controller feeding a sort engine from two requesters and capturing max/sum per frame.
// Optional idle-timeout early frame end is enabled by defining SORT_CTRL_TIMEOUT_EN.
module sort_frame_ctrl
  import sort_pkg::*;
#(
  parameter int W         = 12,
  parameter int FRAME_LEN = 64,
  parameter int DRAIN     = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   synrst,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic                   AutoRestart,
  sort_frame_ctrl_if.slave       req_if,
  output logic                   SortClr,
  output logic                   SortEn,
  output logic [W-1:0]           SortData,
  input  logic [W-1:0]           EngMax,
  input  logic [W+SUM_EXTRA-1:0] EngSum,
  output logic [W-1:0]           ResMax,
  output logic [W+SUM_EXTRA-1:0] ResSum,
  output logic                   ResValid,
  input  logic                   ResReady,
  output logic                   ResShort,
  output logic                   Busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int SW = W + SUM_EXTRA;

  if (FRAME_LEN < 2 || FRAME_LEN > 4095 || DRAIN < 1 || DRAIN > 15 || TIMEOUT < 1) begin : g_param_err
    $error("sort_frame_ctrl: parameter out of range");
  end

  sort_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    drain_q, drain_d;
  logic          short_q, short_d;
  logic          sort_clr_q, sort_clr_d;
  logic          sort_en_q, sort_en_d;
  logic [W-1:0]  sort_data_q, sort_data_d;
  logic [W-1:0]  res_max_q, res_max_d;
  logic [SW-1:0] res_sum_q, res_sum_d;
  logic          res_valid_q, res_valid_d;
  logic          res_short_q, res_short_d;
  logic [1:0]    grant;
  logic          accept;
  logic          feed_en;
  logic          timeout;

  // Abort blocks acceptance so an aborted frame never swallows a requester's sample
  assign feed_en = (state_q == ST_FEED) && !Abort && !synrst;

  sort_rr_arb2 u_arb (
    .clk     (clk),
    .synrst  (synrst),
    .req_i   ({req_if.ReqB, req_if.ReqA}),
    .en_i    (feed_en),
    .grant_o (grant)
  );

  assign accept      = grant[0] | grant[1];
  assign req_if.AckA = grant[0];
  assign req_if.AckB = grant[1];

`ifdef SORT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d  = idle_q;
    timeout = (state_q == ST_FEED) && !accept && (idle_q == '0);
    if (state_q != ST_FEED || accept) begin
      idle_d = TW'(TIMEOUT - 1);
    end else if (idle_q != '0) begin
      idle_d = idle_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (synrst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    short_d     = short_q;
    res_max_d   = res_max_q;
    res_sum_d   = res_sum_q;
    res_valid_d = res_valid_q;
    res_short_d = res_short_q;
    sort_en_d   = accept;
    sort_data_d = sort_data_q;
    if (accept) begin
      sort_data_d = grant[1] ? req_if.DataB : req_if.DataA;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (Start && !Abort) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        short_d = 1'b0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (accept && cnt_q == CW'(FRAME_LEN - 1)) begin
          state_d = ST_DRAIN;
          drain_d = 4'(DRAIN - 1);
        end else if (timeout) begin
          state_d = ST_DRAIN;
          drain_d = 4'(DRAIN - 1);
          short_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d     = ST_HOLD;
          res_max_d   = EngMax;
          res_sum_d   = EngSum;
          res_short_d = short_q;
          res_valid_d = 1'b1;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (ResReady) begin
          res_valid_d = 1'b0;
          state_d     = AutoRestart ? ST_CLEAR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards the frame, including a capture that would land on this edge
    if (Abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
      res_max_d   = res_max_q;
      res_sum_d   = res_sum_q;
      res_short_d = res_short_q;
    end

    sort_clr_d = (state_d == ST_CLEAR) || (Abort && state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (synrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drain_q     <= 4'd0;
      short_q     <= 1'b0;
      sort_clr_q  <= 1'b1;
      sort_en_q   <= 1'b0;
      sort_data_q <= '0;
      res_max_q   <= '0;
      res_sum_q   <= '0;
      res_valid_q <= 1'b0;
      res_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      short_q     <= short_d;
      sort_clr_q  <= sort_clr_d;
      sort_en_q   <= sort_en_d;
      sort_data_q <= sort_data_d;
      res_max_q   <= res_max_d;
      res_sum_q   <= res_sum_d;
      res_valid_q <= res_valid_d;
      res_short_q <= res_short_d;
    end
  end

  assign SortClr  = sort_clr_q;
  assign SortEn   = sort_en_q;
  assign SortData = sort_data_q;
  assign ResMax   = res_max_q;
  assign ResSum   = res_sum_q;
  assign ResValid = res_valid_q;
  assign ResShort = res_short_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench for sort_frame_ctrl with a behavioural max/sum engine on the sample path.
module tb_sort_frame_ctrl;
  import sort_pkg::*;

  localparam int W  = 12;
  localparam int FL = 4;
  localparam int DR = 4;
  localparam int TO = 8;
  localparam int SW = W + SUM_EXTRA;

  logic clk = 1'b0;
  logic synrst, Start, Abort, AutoRestart, ResReady;
  logic SortClr, SortEn, ResValid, ResShort, Busy;
  logic [W-1:0]  SortData, ResMax;
  logic [W-1:0]  EngMax = '0;
  logic [SW-1:0] EngSum = '0;
  logic [SW-1:0] ResSum;
  int checks = 0;
  int errors = 0;
  int en_pulses = 0;

  sort_frame_ctrl_if #(.W(W)) bus();

  sort_frame_ctrl #(.W(W), .FRAME_LEN(FL), .DRAIN(DR), .TIMEOUT(TO)) dut (
    .clk(clk), .synrst(synrst), .Start(Start), .Abort(Abort), .AutoRestart(AutoRestart),
    .req_if(bus), .SortClr(SortClr), .SortEn(SortEn), .SortData(SortData),
    .EngMax(EngMax), .EngSum(EngSum), .ResMax(ResMax), .ResSum(ResSum),
    .ResValid(ResValid), .ResReady(ResReady), .ResShort(ResShort), .Busy(Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (SortClr === 1'b1) begin
      EngMax <= '0;
      EngSum <= '0;
    end else if (SortEn === 1'b1) begin
      if (SortData > EngMax) EngMax <= SortData;
      EngSum <= EngSum + SW'(SortData);
    end
    if (SortEn === 1'b1) en_pulses <= en_pulses + 1;
  end

  task automatic do_reset();
    synrst = 1'b1; Start = 1'b0; Abort = 1'b0; AutoRestart = 1'b0; ResReady = 1'b0;
    bus.ReqA = 1'b0; bus.ReqB = 1'b0; bus.DataA = '0; bus.DataB = '0;
    repeat (2) @(negedge clk);
    synrst = 1'b0;
  endtask

  // leaves the caller in the CLEAR cycle, just after the negedge
  task automatic start_frame();
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
  endtask

  task automatic test_reset();
    synrst = 1'b1; Start = 1'b1; Abort = 1'b0; AutoRestart = 1'b0; ResReady = 1'b0;
    bus.ReqA = 1'b1; bus.ReqB = 1'b1; bus.DataA = 12'd7; bus.DataB = 12'd8;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (SortClr !== 1'b1) begin errors++; $display("FAIL reset_sortclr: got %b want 1", SortClr); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if ({SortEn, ResValid, ResShort} !== 3'b000) begin errors++; $display("FAIL reset_flags: en/valid/short got %b want 000", {SortEn, ResValid, ResShort}); end
    checks++; if ({bus.AckA, bus.AckB} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {bus.AckA, bus.AckB}); end
    checks++; if (ResMax !== '0 || ResSum !== '0 || SortData !== '0) begin errors++; $display("FAIL reset_data: max %0d sum %0d sdata %0d want 0", ResMax, ResSum, SortData); end
    @(negedge clk); synrst = 1'b0; Start = 1'b0; bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    @(negedge clk); #1;
    checks++; if (SortClr !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: clr %b busy %b want 0 0", SortClr, Busy); end
  endtask

  task automatic test_single_a();
    int d[4] = '{5, 9, 3, 7};
    int p0;
    do_reset();
    p0 = en_pulses;
    start_frame();
    bus.ReqA = 1'b1; bus.DataA = 12'd55;
    #1;
    checks++; if (SortClr !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL clear_cycle: clr %b busy %b want 1 1", SortClr, Busy); end
    checks++; if (bus.AckA !== 1'b0) begin errors++; $display("FAIL clear_no_ack: got %b want 0", bus.AckA); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.DataA = W'(d[i]); #1;
      checks++; if ({bus.AckA, bus.AckB} !== 2'b10) begin errors++; $display("FAIL single_ack[%0d]: got %b want 10", i, {bus.AckA, bus.AckB}); end
      checks++; if (SortEn !== (i > 0)) begin errors++; $display("FAIL single_en[%0d]: got %b want %b", i, SortEn, (i > 0)); end
      if (i > 0) begin
        checks++; if (SortData !== W'(d[i-1])) begin errors++; $display("FAIL single_data[%0d]: got %0d want %0d", i, SortData, d[i-1]); end
      end
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); bus.DataA = 12'd50; #1;
      checks++; if (bus.AckA !== 1'b0) begin errors++; $display("FAIL drain_no_ack[%0d]: got %b want 0", k, bus.AckA); end
      checks++; if (SortEn !== (k == 1) || (k == 1 && SortData !== 12'd7)) begin errors++; $display("FAIL drain_en[%0d]: en %b data %0d", k, SortEn, SortData); end
      checks++; if (ResValid !== (k == 5)) begin errors++; $display("FAIL valid_latency[%0d]: got %b want %b", k, ResValid, (k == 5)); end
    end
    checks++; if (en_pulses - p0 !== 4) begin errors++; $display("FAIL sorten_count: got %0d want 4", en_pulses - p0); end
    checks++; if (ResMax !== 12'd9 || ResSum !== 16'd24) begin errors++; $display("FAIL single_result: max %0d sum %0d want 9 24", ResMax, ResSum); end
    checks++; if (ResShort !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL single_flags: short %b busy %b want 0 1", ResShort, Busy); end
  endtask

  task automatic test_hold_stall();
    bus.ReqA = 1'b1; bus.ReqB = 1'b1; ResReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checks++; if (ResValid !== 1'b1 || ResMax !== 12'd9 || ResSum !== 16'd24) begin errors++; $display("FAIL hold_stable[%0d]: valid %b max %0d sum %0d want 1 9 24", k, ResValid, ResMax, ResSum); end
      checks++; if ({bus.AckA, bus.AckB} !== 2'b00) begin errors++; $display("FAIL hold_no_ack[%0d]: got %b want 00", k, {bus.AckA, bus.AckB}); end
    end
    @(negedge clk); ResReady = 1'b1; bus.ReqA = 1'b0; bus.ReqB = 1'b0; #1;
    checks++; if (ResValid !== 1'b1) begin errors++; $display("FAIL hold_ready_cycle: got %b want 1", ResValid); end
    @(negedge clk); ResReady = 1'b0; #1;
    checks++; if (ResValid !== 1'b0 || Busy !== 1'b0 || ResMax !== 12'd9) begin errors++; $display("FAIL hold_release: valid %b busy %b max %0d want 0 0 9", ResValid, Busy, ResMax); end
  endtask

  task automatic test_round_robin();
    bit found;
    do_reset();
    start_frame();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.ReqA = 1'b1; bus.ReqB = 1'b1; bus.DataA = W'(10 + i); bus.DataB = W'(20 + i); #1;
      checks++; if ({bus.AckA, bus.AckB} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", i, {bus.AckA, bus.AckB}, ((i % 2 == 0) ? 2'b10 : 2'b01)); end
    end
    @(negedge clk); bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (ResValid === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rr_valid_wait: ResValid 0 want 1"); end
    checks++; if (ResMax !== 12'd23 || ResSum !== 16'd66) begin errors++; $display("FAIL rr_result: max %0d sum %0d want 23 66", ResMax, ResSum); end
    @(negedge clk); ResReady = 1'b1;
    @(negedge clk); ResReady = 1'b0;
  endtask

  task automatic test_abort();
    start_frame();
    @(negedge clk); bus.ReqA = 1'b1; bus.DataA = 12'd100; #1;
    checks++; if (bus.AckA !== 1'b1) begin errors++; $display("FAIL abort_first_ack: got %b want 1", bus.AckA); end
    @(negedge clk); bus.ReqA = 1'b0; Abort = 1'b1; #1;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_cycle_busy: got %b want 1", Busy); end
    @(negedge clk); Abort = 1'b0; #1;
    checks++; if (Busy !== 1'b0 || SortClr !== 1'b1) begin errors++; $display("FAIL abort_idle: busy %b clr %b want 0 1", Busy, SortClr); end
    @(negedge clk); #1;
    checks++; if (SortClr !== 1'b0) begin errors++; $display("FAIL abort_clr_once: got %b want 0", SortClr); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      checks++; if (ResValid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL abort_no_valid[%0d]: valid %b busy %b want 0 0", k, ResValid, Busy); end
    end
    checks++; if (ResMax !== 12'd23 || ResSum !== 16'd66) begin errors++; $display("FAIL abort_result_kept: max %0d sum %0d want 23 66", ResMax, ResSum); end
    @(negedge clk); Start = 1'b1; Abort = 1'b1;
    @(negedge clk); Start = 1'b0; Abort = 1'b0; #1;
    checks++; if (Busy !== 1'b0 || SortClr !== 1'b0) begin errors++; $display("FAIL start_abort_same: busy %b clr %b want 0 0", Busy, SortClr); end
  endtask

  task automatic test_auto_restart();
    bit found, busy_ok;
    AutoRestart = 1'b1; ResReady = 1'b1;
    start_frame();
    bus.ReqA = 1'b1; bus.DataA = 12'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.DataA = W'(i + 1); #1;
      checks++; if (bus.AckA !== 1'b1) begin errors++; $display("FAIL auto_ack[%0d]: got %b want 1", i, bus.AckA); end
    end
    @(negedge clk); bus.DataA = 12'd99;
    found = 1'b0; busy_ok = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (ResValid === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL auto_valid_wait: ResValid 0 want 1"); end
    checks++; if (ResMax !== 12'd4 || ResSum !== 16'd10) begin errors++; $display("FAIL auto_result: max %0d sum %0d want 4 10", ResMax, ResSum); end
    @(negedge clk); #1;
    checks++; if (ResValid !== 1'b0 || Busy !== 1'b1 || SortClr !== 1'b1 || bus.AckA !== 1'b0) begin errors++; $display("FAIL auto_clear: valid %b busy %b clr %b ack %b want 0 1 1 0", ResValid, Busy, SortClr, bus.AckA); end
    @(negedge clk); Start = 1'b1; #1;
    checks++; if (bus.AckA !== 1'b1 || Busy !== 1'b1 || SortClr !== 1'b0) begin errors++; $display("FAIL auto_feed: ack %b busy %b clr %b want 1 1 0", bus.AckA, Busy, SortClr); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL auto_busy_held: Busy dropped want 1"); end
    @(negedge clk); Start = 1'b0; bus.ReqA = 1'b0; Abort = 1'b1;
    @(negedge clk); Abort = 1'b0; AutoRestart = 1'b0; ResReady = 1'b0; #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL auto_abort_idle: got %b want 0", Busy); end
  endtask

`ifdef SORT_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start_frame();
    bus.ReqA = 1'b1;
    @(negedge clk); bus.DataA = 12'd6; #1;
    checks++; if (bus.AckA !== 1'b1) begin errors++; $display("FAIL to_ack0: got %b want 1", bus.AckA); end
    @(negedge clk); bus.DataA = 12'd2; #1;
    checks++; if (bus.AckA !== 1'b1) begin errors++; $display("FAIL to_ack1: got %b want 1", bus.AckA); end
    @(negedge clk); bus.ReqA = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      checks++; if (ResValid !== (k == 13)) begin errors++; $display("FAIL to_latency[%0d]: got %b want %b", k, ResValid, (k == 13)); end
    end
    checks++; if (ResShort !== 1'b1 || ResMax !== 12'd6 || ResSum !== 16'd8) begin errors++; $display("FAIL to_result: short %b max %0d sum %0d want 1 6 8", ResShort, ResMax, ResSum); end
    @(negedge clk); ResReady = 1'b1;
    @(negedge clk); ResReady = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    start_frame();
    bus.ReqA = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.DataA = W'(6 - 4 * i);
    end
    @(negedge clk); bus.ReqA = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (Busy !== 1'b1 || ResValid !== 1'b0) begin errors++; $display("FAIL no_to_wait: busy %b valid %b want 1 0", Busy, ResValid); end
    @(negedge clk); bus.ReqA = 1'b1; bus.DataA = 12'd1;
    @(negedge clk); bus.DataA = 12'd3; #1;
    checks++; if (bus.AckA !== 1'b1) begin errors++; $display("FAIL no_to_resume: got %b want 1", bus.AckA); end
    @(negedge clk); bus.ReqA = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (ResValid !== 1'b1 || ResShort !== 1'b0 || ResMax !== 12'd6 || ResSum !== 16'd12) begin errors++; $display("FAIL no_to_result: valid %b short %b max %0d sum %0d want 1 0 6 12", ResValid, ResShort, ResMax, ResSum); end
    @(negedge clk); ResReady = 1'b1;
    @(negedge clk); ResReady = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_hold_stall();
    test_round_robin();
    test_abort();
    test_auto_restart();
`ifdef SORT_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
